// File: rtl/board_io_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : board_io_ctrl
// Brief    : Switch/button synchroniser + debouncer, sticky button IRQs, LED
//            register. Optional LED PWM dimming via macro BOARD_IO_PWM_EN.
// Revision : 1.0 - initial release
// ============================================================================
module board_io_ctrl #(
  parameter int SW_WIDTH        = 16,
  parameter int BTN_COUNT       = 1,
  parameter int LED_WIDTH       = 16,
  parameter int DEBOUNCE_CYCLES = 800000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic                 clk_i,
  input  logic                 srstn_i,
  input  logic [SW_WIDTH-1:0]  sw_i,
  input  logic [BTN_COUNT-1:0] btn_i,
  output logic [SW_WIDTH-1:0]  sw_o,
  output logic [BTN_COUNT-1:0] btn_o,
  output logic [BTN_COUNT-1:0] btn_irq_o,
  output logic                 btn_irq_any_o,
  input  logic [BTN_COUNT-1:0] irq_ack_i,
  input  logic [LED_WIDTH-1:0] led_i,
  input  logic                 led_we_i,
  input  logic [7:0]           brightness_i,
  output logic [LED_WIDTH-1:0] led_o
);

  localparam int NCH = SW_WIDTH + BTN_COUNT;
  // In bypass mode the stable register itself acts as the last synchroniser stage.
  localparam int SYNC_FF = (DEBOUNCE_CYCLES == 0) ? SYNC_STAGES - 1 : SYNC_STAGES;

  logic [NCH-1:0]       sync_d [SYNC_FF];
  logic [NCH-1:0]       sync_q [SYNC_FF];
  logic [NCH-1:0]       w_sync;
  logic [NCH-1:0]       stable_d;
  logic [NCH-1:0]       stable_q;
  logic [BTN_COUNT-1:0] w_btn_rise;
  logic [BTN_COUNT-1:0] irq_d;
  logic [BTN_COUNT-1:0] irq_q;
  logic [LED_WIDTH-1:0] led_d;
  logic [LED_WIDTH-1:0] led_q;

  always_comb begin
    sync_d[0] = {btn_i, sw_i};
    for (int i = 1; i < SYNC_FF; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  assign w_sync = sync_q[SYNC_FF-1];

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      assign stable_d = w_sync;
    end else begin : g_debounce
      localparam int            CW      = $clog2(DEBOUNCE_CYCLES + 1);
      localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

      logic [CW-1:0] cnt_d [NCH];
      logic [CW-1:0] cnt_q [NCH];

      // Counter tracks consecutive disagreement; it never runs past CNT_MAX.
      always_comb begin
        for (int i = 0; i < NCH; i++) begin
          stable_d[i] = stable_q[i];
          cnt_d[i]    = '0;
          if (w_sync[i] != stable_q[i]) begin
            if (cnt_q[i] == CNT_MAX) begin
              stable_d[i] = w_sync[i];
            end else begin
              cnt_d[i] = cnt_q[i] + CW'(1);
            end
          end
        end
      end

      always_ff @(posedge clk_i) begin
        if (!srstn_i) begin
          for (int i = 0; i < NCH; i++) begin
            cnt_q[i] <= '0;
          end
        end else begin
          for (int i = 0; i < NCH; i++) begin
            cnt_q[i] <= cnt_d[i];
          end
        end
      end
    end
  endgenerate

  // A set on the same edge as an ack wins.
  always_comb begin
    w_btn_rise = stable_d[NCH-1:SW_WIDTH] & ~stable_q[NCH-1:SW_WIDTH];
    irq_d      = (irq_q & ~irq_ack_i) | w_btn_rise;
    led_d      = led_we_i ? led_i : led_q;
  end

  always_ff @(posedge clk_i) begin
    if (!srstn_i) begin
      for (int i = 0; i < SYNC_FF; i++) begin
        sync_q[i] <= '0;
      end
      stable_q <= '0;
      irq_q    <= '0;
      led_q    <= '0;
    end else begin
      for (int i = 0; i < SYNC_FF; i++) begin
        sync_q[i] <= sync_d[i];
      end
      stable_q <= stable_d;
      irq_q    <= irq_d;
      led_q    <= led_d;
    end
  end

  assign sw_o          = stable_q[SW_WIDTH-1:0];
  assign btn_o         = stable_q[NCH-1:SW_WIDTH];
  assign btn_irq_o     = irq_q;
  assign btn_irq_any_o = |irq_q;

`ifdef BOARD_IO_PWM_EN
  logic [7:0] pwm_cnt_d;
  logic [7:0] pwm_cnt_q;
  logic       w_pwm_on;

  always_comb begin
    pwm_cnt_d = pwm_cnt_q + 8'd1;
    w_pwm_on  = (pwm_cnt_q < brightness_i) || (brightness_i == 8'hFF);
  end

  always_ff @(posedge clk_i) begin
    if (!srstn_i) begin
      pwm_cnt_q <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
    end
  end

  assign led_o = led_q & {LED_WIDTH{w_pwm_on}};
`else
  logic unused_brightness;
  assign unused_brightness = ^brightness_i;
  assign led_o             = led_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_board_io_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_board_io_ctrl
// Brief    : Self-checking bench for board_io_ctrl (DEBOUNCE_CYCLES=4,
//            SYNC_STAGES=2) against a sample-window reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_board_io_ctrl;

  localparam int SW_W  = 8;
  localparam int BTN_N = 2;
  localparam int LED_W = 16;
  localparam int DB    = 4;
  localparam int SS    = 2;
  localparam int NCH   = SW_W + BTN_N;

  logic             clk = 1'b0;
  logic             srstn;
  logic [SW_W-1:0]  sw;
  logic [BTN_N-1:0] btn;
  logic [BTN_N-1:0] ack;
  logic [LED_W-1:0] led_in;
  logic             led_we;
  logic [7:0]       bright;
  logic [SW_W-1:0]  sw_o;
  logic [BTN_N-1:0] btn_o;
  logic [BTN_N-1:0] irq_o;
  logic             irq_any;
  logic [LED_W-1:0] led_o;

  int checks = 0;
  int errors = 0;

  // Reference model: raw sample history (newest first), stable levels, flags.
  logic [NCH-1:0]   hq [$];
  logic [NCH-1:0]   m_stable;
  logic [BTN_N-1:0] m_irq;
  logic [LED_W-1:0] m_led;
  logic [7:0]       m_pwm;

  board_io_ctrl #(
    .SW_WIDTH(SW_W), .BTN_COUNT(BTN_N), .LED_WIDTH(LED_W),
    .DEBOUNCE_CYCLES(DB), .SYNC_STAGES(SS)
  ) dut (
    .clk_i(clk), .srstn_i(srstn), .sw_i(sw), .btn_i(btn),
    .sw_o(sw_o), .btn_o(btn_o), .btn_irq_o(irq_o), .btn_irq_any_o(irq_any),
    .irq_ack_i(ack), .led_i(led_in), .led_we_i(led_we),
    .brightness_i(bright), .led_o(led_o)
  );

  always #5 clk = ~clk;

  // A level flips once the DB synchronised samples before the current edge
  // all disagree with it; synchronised sample at edge t is the raw sample at t-SS.
  task automatic tick();
    logic [NCH-1:0]   nxt;
    logic [BTN_N-1:0] rise;
    logic             all_diff;
    @(posedge clk);
    if (!srstn) begin
      hq.delete();
      for (int k = 0; k < SS + DB; k++) hq.push_back('0);
      m_stable = '0;
      m_irq    = '0;
      m_led    = '0;
      m_pwm    = 8'd0;
    end else begin
      hq.push_front({btn, sw});
      void'(hq.pop_back());
      nxt = m_stable;
      for (int c = 0; c < NCH; c++) begin
        all_diff = 1'b1;
        for (int k = SS; k < SS + DB; k++) begin
          if (hq[k][c] == m_stable[c]) all_diff = 1'b0;
        end
        if (all_diff) nxt[c] = ~m_stable[c];
      end
      rise     = nxt[NCH-1:SW_W] & ~m_stable[NCH-1:SW_W];
      m_irq    = (m_irq & ~ack) | rise;
      if (led_we) m_led = led_in;
      m_pwm    = m_pwm + 8'd1;
      m_stable = nxt;
    end
    #1;
  endtask

  function automatic logic [LED_W-1:0] exp_led();
`ifdef BOARD_IO_PWM_EN
    return ((m_pwm < bright) || (bright == 8'hFF)) ? m_led : '0;
`else
    return m_led;
`endif
  endfunction

  task automatic do_reset();
    srstn = 1'b0; sw = '0; btn = '0; ack = '0; led_we = 1'b0;
    tick();
    srstn = 1'b1;
  endtask

  task automatic test_reset();
    srstn = 1'b0; sw = 8'hFF; btn = 2'b11; ack = '0;
    led_we = 1'b1; led_in = 16'hFFFF;
    tick(); tick();
    checks++; if (sw_o !== '0) begin errors++; $display("FAIL reset_sw got %h exp 00", sw_o); end
    checks++; if (btn_o !== '0) begin errors++; $display("FAIL reset_btn got %b exp 00", btn_o); end
    checks++; if (irq_o !== '0) begin errors++; $display("FAIL reset_irq got %b exp 00", irq_o); end
    checks++; if (irq_any !== 1'b0) begin errors++; $display("FAIL reset_any got %b exp 0", irq_any); end
    checks++; if (led_o !== '0) begin errors++; $display("FAIL reset_led got %h exp 0000", led_o); end
    srstn = 1'b1; sw = '0; btn = '0; led_we = 1'b0;
    for (int n = 0; n < 8; n++) tick();
  endtask

  task automatic test_press_latency();
    logic exp;
    do_reset();
    btn = 2'b01;
    for (int n = 1; n <= 8; n++) begin
      tick();
      exp = (n >= 6);
      checks++;
      if ({btn_o[0], irq_o[0], irq_any} !== {3{exp}}) begin
        errors++;
        $display("FAIL press_latency cyc %0d got btn/irq/any %b%b%b exp %b", n, btn_o[0], irq_o[0], irq_any, exp);
      end
    end
  endtask

  task automatic test_glitch();
    do_reset();
    btn = 2'b01;
    tick(); tick(); tick();
    btn = 2'b00;
    for (int n = 0; n < 10; n++) begin
      tick();
      checks++;
      if (btn_o[0] !== 1'b0 || irq_o[0] !== 1'b0) begin
        errors++;
        $display("FAIL glitch cyc %0d got btn %b irq %b exp 0 0", n, btn_o[0], irq_o[0]);
      end
    end
  endtask

  task automatic test_ack();
    do_reset();
    btn = 2'b01;
    repeat (6) tick();
    btn = 2'b00;
    repeat (6) tick();
    checks++; if (btn_o[0] !== 1'b0) begin errors++; $display("FAIL release_btn got %b exp 0", btn_o[0]); end
    checks++; if (irq_o[0] !== 1'b1) begin errors++; $display("FAIL release_keeps_irq got %b exp 1", irq_o[0]); end
    ack = 2'b01; tick(); ack = 2'b00;
    checks++; if (irq_o[0] !== 1'b0) begin errors++; $display("FAIL ack_clear got %b exp 0", irq_o[0]); end
    btn = 2'b01;
    repeat (5) tick();
    ack = 2'b01; tick(); ack = 2'b00;
    checks++; if (irq_o[0] !== 1'b1 || btn_o[0] !== 1'b1) begin
      errors++; $display("FAIL set_beats_ack got irq %b btn %b exp 1 1", irq_o[0], btn_o[0]);
    end
    tick();
    checks++; if (irq_o[0] !== 1'b1) begin errors++; $display("FAIL irq_sticky got %b exp 1", irq_o[0]); end
    ack = 2'b01; tick(); ack = 2'b00;
    checks++; if (irq_o[0] !== 1'b0 || irq_any !== 1'b0) begin
      errors++; $display("FAIL ack_later got irq %b any %b exp 0 0", irq_o[0], irq_any);
    end
    btn = 2'b00;
  endtask

  task automatic test_led();
    int lit;
    bright = 8'h40; led_in = 16'hA5A5; led_we = 1'b1;
    tick();
    led_we = 1'b0; led_in = 16'hFFFF;
`ifdef BOARD_IO_PWM_EN
    lit = 0;
    for (int n = 0; n < 256; n++) begin
      if (led_o === 16'hA5A5) lit++;
      else if (led_o !== 16'h0000) begin
        checks++; errors++; $display("FAIL pwm_level got %h exp A5A5 or 0000", led_o);
      end
      tick();
    end
    checks++; if (lit !== 64) begin errors++; $display("FAIL pwm_duty got %0d exp 64", lit); end
`else
    lit = 0;
    checks++; if (led_o !== 16'hA5A5) begin errors++; $display("FAIL led_write got %h exp A5A5", led_o); end
    tick();
    checks++; if (led_o !== 16'hA5A5) begin errors++; $display("FAIL led_hold got %h exp A5A5", led_o); end
`endif
  endtask

  task automatic test_reset_mid();
    logic exp;
    do_reset();
    led_we = 1'b1; led_in = 16'h1234; tick(); led_we = 1'b0;
    btn = 2'b01;
    tick(); tick();
    srstn = 1'b0;
    tick();
    srstn = 1'b1;
    checks++;
    if (sw_o !== '0 || btn_o !== '0 || irq_o !== '0 || irq_any !== 1'b0 || led_o !== '0) begin
      errors++;
      $display("FAIL mid_reset got sw %h btn %b irq %b any %b led %h exp all 0", sw_o, btn_o, irq_o, irq_any, led_o);
    end
    for (int n = 1; n <= 7; n++) begin
      tick();
      exp = (n >= 6);
      checks++;
      if (btn_o[0] !== exp || irq_o[0] !== exp) begin
        errors++;
        $display("FAIL post_reset cyc %0d got btn %b irq %b exp %b", n, btn_o[0], irq_o[0], exp);
      end
    end
    btn = 2'b00;
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 800; n++) begin
      srstn  = ($urandom_range(149) != 0);
      if ($urandom_range(7) == 0) sw  = sw  ^ SW_W'($urandom);
      if ($urandom_range(7) == 0) btn = btn ^ BTN_N'($urandom);
      ack    = ($urandom_range(5) == 0) ? BTN_N'($urandom) : '0;
      led_we = ($urandom_range(3) == 0);
      led_in = LED_W'($urandom);
      if ($urandom_range(31) == 0) bright = 8'($urandom);
      tick();
      checks++; if (sw_o !== m_stable[SW_W-1:0]) begin errors++; $display("FAIL rnd_sw cyc %0d got %h exp %h", n, sw_o, m_stable[SW_W-1:0]); end
      checks++; if (btn_o !== m_stable[NCH-1:SW_W]) begin errors++; $display("FAIL rnd_btn cyc %0d got %b exp %b", n, btn_o, m_stable[NCH-1:SW_W]); end
      checks++; if (irq_o !== m_irq) begin errors++; $display("FAIL rnd_irq cyc %0d got %b exp %b", n, irq_o, m_irq); end
      checks++; if (irq_any !== (|m_irq)) begin errors++; $display("FAIL rnd_any cyc %0d got %b exp %b", n, irq_any, |m_irq); end
      checks++; if (led_o !== exp_led()) begin errors++; $display("FAIL rnd_led cyc %0d got %h exp %h", n, led_o, exp_led()); end
    end
  endtask

  initial begin
    srstn = 1'b0; sw = '0; btn = '0; ack = '0;
    led_in = '0; led_we = 1'b0; bright = 8'h00;
    for (int k = 0; k < SS + DB; k++) hq.push_back('0);
    m_stable = '0; m_irq = '0; m_led = '0; m_pwm = '0;
    test_reset();
    test_press_latency();
    test_glitch();
    test_ack();
    test_led();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got no finish exp finish before 2ms");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
